// File: rtl/serial_sub_pkg.sv
// Shared FSM encoding and sizing helper for the serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count n slices; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_subtractor_slice.sv
// STEP-bit ripple-borrow subtractor slice: d = x - y - bin, bout = final borrow.
module full_subtractor_slice #(
    parameter int unsigned STEP = 1
) (
    input  logic [STEP-1:0] x,
    input  logic [STEP-1:0] y,
    input  logic            bin,
    output logic [STEP-1:0] d,
    output logic            bout
);

    always_comb begin
        logic b;
        b = bin;
        d = '0;
        for (int i = 0; i < int'(STEP); i++) begin
            d[i] = x[i] ^ y[i] ^ b;
            b    = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & b);
        end
        bout = b;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor processing STEP bits per cycle, LSB slice first.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed Overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEP  = 1
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [WIDTH-1:0] Xin,
    input  logic [WIDTH-1:0] Yin,
    input  logic             BorrowIn,
    output logic [WIDTH-1:0] Diff,
    output logic             BorrowOut,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             Overflow,
`endif
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned NSLICE = WIDTH / STEP;
    localparam int unsigned CNT_W  = cnt_width(NSLICE);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic [STEP-1:0]  sl_x, sl_y, sl_d;
    logic             sl_bout;
    logic             last_slice;

    assign sl_x       = x_q[int'(cnt_q) * STEP +: STEP];
    assign sl_y       = y_q[int'(cnt_q) * STEP +: STEP];
    assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));

    full_subtractor_slice #(
        .STEP (STEP)
    ) u_slice (
        .x    (sl_x),
        .y    (sl_y),
        .bin  (borrow_q),
        .d    (sl_d),
        .bout (sl_bout)
    );

    // Next-state and next-register values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d  = RUN;
                    x_d      = Xin;
                    y_d      = Yin;
                    borrow_d = BorrowIn;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                diff_d[int'(cnt_q) * STEP +: STEP] = sl_d;
                borrow_d = sl_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_slice) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    bout_d  = sl_bout;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d   = (x_q[WIDTH-1] != y_q[WIDTH-1]) &&
                              (sl_d[STEP-1] != x_q[WIDTH-1]);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign Diff      = diff_q;
    assign BorrowOut = bout_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign Overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: 8-bit STEP=1 and 8-bit STEP=4 instances.
// Overflow checks are compiled in when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

    logic       clk;
    logic       rstn;
    logic       start [2];
    logic [7:0] xin, yin;
    logic       bin;
    logic [7:0] dut_diff [2];
    logic       dut_bout [2];
    logic       dut_busy [2];
    logic       dut_done [2];
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic       dut_ovf  [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .STEP(1)) u_s1 (
        .Clk       (clk),
        .ResetN    (rstn),
        .Start     (start[0]),
        .Xin       (xin),
        .Yin       (yin),
        .BorrowIn  (bin),
        .Diff      (dut_diff[0]),
        .BorrowOut (dut_bout[0]),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .Overflow  (dut_ovf[0]),
`endif
        .Busy      (dut_busy[0]),
        .Done      (dut_done[0])
    );

    serial_subtractor #(.WIDTH(8), .STEP(4)) u_s4 (
        .Clk       (clk),
        .ResetN    (rstn),
        .Start     (start[1]),
        .Xin       (xin),
        .Yin       (yin),
        .BorrowIn  (bin),
        .Diff      (dut_diff[1]),
        .BorrowOut (dut_bout[1]),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .Overflow  (dut_ovf[1]),
`endif
        .Busy      (dut_busy[1]),
        .Done      (dut_done[1])
    );

    typedef struct {
        int         sel;
        logic [7:0] x;
        logic [7:0] y;
        logic       b;
        logic [7:0] d;
        logic       bo;
        int         lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [7:0] x, input logic [7:0] y, input logic b,
                                  output logic [7:0] d, output logic bo, output logic ov);
        int r;
        int s;
        r  = int'(x) - int'(y) - int'(b);
        s  = int'($signed(x)) - int'($signed(y)) - int'(b);
        d  = 8'(r);
        bo = (r < 0);
        ov = (s < -128) || (s > 127);
    endfunction

    function automatic int exp_lat(input int sel);
        return (sel == 0) ? 8 : 2;
    endfunction

    // One operation: accept Start, count cycles to Done (bounded), return results.
    task automatic do_op(input int sel, input logic [7:0] x, input logic [7:0] y, input logic b,
                         output logic [7:0] d, output logic bo, output logic ov, output int lat);
        @(negedge clk);
        xin = x; yin = y; bin = b; start[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
        lat = 0;
        while (dut_done[sel] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        d  = dut_diff[sel];
        bo = dut_bout[sel];
`ifdef SERIAL_SUB_OVERFLOW_EN
        ov = dut_ovf[sel];
`else
        ov = 1'b0;
`endif
    endtask

    initial begin
        logic [7:0] d, ed;
        logic       bo, ebo, ov, eov;
        int         lat;
        logic       seen;

        vecs[0] = '{0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 8};
        vecs[1] = '{0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 8};
        vecs[2] = '{1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 2};
        vecs[3] = '{0, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 8};
        vecs[4] = '{0, 8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 8};
        vecs[5] = '{0, 8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 8};
        vecs[6] = '{1, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 2};
        vecs[7] = '{1, 8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 2};

        rstn = 1'b0; start[0] = 1'b0; start[1] = 1'b0;
        xin = 8'h00; yin = 8'h00; bin = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst_diff%0d", s), 64'(dut_diff[s]), 64'h0);
            check($sformatf("rst_bout%0d", s), 64'(dut_bout[s]), 64'h0);
            check($sformatf("rst_busy%0d", s), 64'(dut_busy[s]), 64'h0);
            check($sformatf("rst_done%0d", s), 64'(dut_done[s]), 64'h0);
`ifdef SERIAL_SUB_OVERFLOW_EN
            check($sformatf("rst_ovf%0d", s), 64'(dut_ovf[s]), 64'h0);
`endif
        end
        rstn = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].sel, vecs[i].x, vecs[i].y, vecs[i].b, d, bo, ov, lat);
            check($sformatf("vec%0d_diff", i), 64'(d),   64'(vecs[i].d));
            check($sformatf("vec%0d_bout", i), 64'(bo),  64'(vecs[i].bo));
            check($sformatf("vec%0d_lat", i),  64'(lat), 64'(vecs[i].lat));
        end

        // Start with new operands at RUN cycle 3 must be ignored.
        @(negedge clk);
        xin = 8'h37; yin = 8'h12; bin = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("run_busy", 64'(dut_busy[0]), 64'h1);
        lat = 0;
        while (dut_done[0] !== 1'b1 && lat < 100) begin
            if (lat == 2) begin
                xin = 8'hAA; yin = 8'h01; bin = 1'b1; start[0] = 1'b1;
            end else begin
                start[0] = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start[0] = 1'b0;
        check("ign_diff", 64'(dut_diff[0]), 64'h25);
        check("ign_bout", 64'(dut_bout[0]), 64'h0);
        check("ign_lat",  64'(lat),         64'd8);
        check("done_busy", 64'(dut_busy[0]), 64'h0);
        @(negedge clk);
        check("done_pulse", 64'(dut_done[0]), 64'h0);
        repeat (2) @(negedge clk);
        check("hold_diff", 64'(dut_diff[0]), 64'h25);

        // Back-to-back operations from DONE.
        do_op(0, 8'h10, 8'h20, 1'b0, d, bo, ov, lat);
        check("b2b_diff", 64'(d),  64'hF0);
        check("b2b_bout", 64'(bo), 64'h1);
        do_op(0, 8'h64, 8'h32, 1'b1, d, bo, ov, lat);
        check("b2b2_diff", 64'(d),   64'h31);
        check("b2b2_lat",  64'(lat), 64'd8);

        // Reset at RUN cycle 4 aborts with no Done.
        @(negedge clk);
        xin = 8'hC3; yin = 8'h3C; bin = 1'b1; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("abort_diff", 64'(dut_diff[0]), 64'h0);
        check("abort_bout", 64'(dut_bout[0]), 64'h0);
        check("abort_busy", 64'(dut_busy[0]), 64'h0);
        check("abort_done", 64'(dut_done[0]), 64'h0);
        rstn = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (dut_done[0] === 1'b1 || dut_busy[0] === 1'b1) seen = 1'b1;
        end
        check("abort_idle", 64'(seen), 64'h0);

`ifdef SERIAL_SUB_OVERFLOW_EN
        do_op(0, 8'h80, 8'h01, 1'b0, d, bo, ov, lat);
        check("ovf1_diff", 64'(d),  64'h7F);
        check("ovf1_bout", 64'(bo), 64'h0);
        check("ovf1_ovf",  64'(ov), 64'h1);
        do_op(0, 8'h10, 8'h01, 1'b0, d, bo, ov, lat);
        check("ovf0_ovf",  64'(ov), 64'h0);
`endif

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 150; i++) begin
            int         sel;
            logic [7:0] x, y;
            logic       b;
            sel = int'($urandom_range(0, 1));
            x   = 8'($urandom);
            y   = 8'($urandom);
            b   = 1'($urandom);
            model(x, y, b, ed, ebo, eov);
            do_op(sel, x, y, b, d, bo, ov, lat);
            check($sformatf("rnd%0d_diff", i), 64'(d),   64'(ed));
            check($sformatf("rnd%0d_bout", i), 64'(bo),  64'(ebo));
            check($sformatf("rnd%0d_lat", i),  64'(lat), 64'(exp_lat(sel)));
`ifdef SERIAL_SUB_OVERFLOW_EN
            check($sformatf("rnd%0d_ovf", i),  64'(ov),  64'(eov));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
